// File: rtl/sdram_prefetch_buffer_pkg.sv
// Shared types and default widths for the SDRAM read-line prefetch buffer.
package sdram_pkg;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned LINE_WORDS_DEF = 8;
    localparam int unsigned ADDR_W_DEF     = 24;
    localparam int unsigned OFF_W          = $clog2(LINE_WORDS_DEF);
    localparam int unsigned TAG_W          = ADDR_W_DEF - OFF_W;

    typedef enum logic [1:0] {
        IDLE,
        HIT,
        WR_PASS,
        FILL
    } state_e;
endpackage

// File: rtl/sdram_prefetch_buffer_line_store.sv
// One cached line: word array with a single write port, async read port, tag and valid.
module pfb_line_store
    import sdram_pkg::*;
#(
    parameter int unsigned WORDS    = LINE_WORDS_DEF,
    parameter int unsigned IDX_W    = OFF_W,
    parameter int unsigned TAG_BITS = TAG_W
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                wr_en_i,
    input  logic [IDX_W-1:0]    wr_idx_i,
    input  logic [DATA_W-1:0]   wr_data_i,
    input  logic                inval_i,
    input  logic                fill_done_i,
    input  logic [TAG_BITS-1:0] tag_i,
    input  logic [IDX_W-1:0]    rd_idx_i,
    output logic [DATA_W-1:0]   rd_data_o,
    output logic [TAG_BITS-1:0] tag_o,
    output logic                valid_o
);
    logic [DATA_W-1:0]   words_q [WORDS];
    logic [TAG_BITS-1:0] tag_q;
    logic                valid_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
        end else if (inval_i) begin
            valid_q <= 1'b0;
        end else if (fill_done_i) begin
            valid_q <= 1'b1;
            tag_q   <= tag_i;
        end
    end

    // Contents need no reset: valid_q gates every use.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            words_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_o = words_q[rd_idx_i];
    assign tag_o     = tag_q;
    assign valid_o   = valid_q;
endmodule

// File: rtl/sdram_prefetch_buffer.sv
// Single-line read buffer in front of sdram_controller: hits served locally, misses fill the line, writes pass through.
module sdram_prefetch_buffer
    import sdram_pkg::*;
#(
    parameter int unsigned LINE_WORDS      = LINE_WORDS_DEF,
    parameter int unsigned ADDR_W          = ADDR_W_DEF,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] up_address,
    input  logic              up_rw,
    input  logic [DATA_W-1:0] up_data_in,
    output logic [DATA_W-1:0] up_data_out,
    output logic              up_busy,
    input  logic              up_in_valid,
    output logic              up_out_valid,
    input  logic              up_prefetch_step,
    output logic [ADDR_W-1:0] ctl_address,
    output logic              ctl_rw,
    output logic [DATA_W-1:0] ctl_data_in,
    input  logic [DATA_W-1:0] ctl_data_out,
    input  logic              ctl_busy,
    output logic              ctl_in_valid,
    input  logic              ctl_out_valid,
    output logic              ctl_prefetch_step
);
    localparam int unsigned OFF_BITS = $clog2(LINE_WORDS);
    localparam int unsigned TAG_BITS = ADDR_W - OFF_BITS;
    localparam int unsigned CNT_W    = OFF_BITS + 1;
    localparam int unsigned OUT_W    = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] LINE_CNT = CNT_W'(LINE_WORDS);
    localparam logic [CNT_W-1:0] LAST_RC  = CNT_W'(LINE_WORDS - 1);
    localparam logic [OUT_W-1:0] MAX_OUT  = OUT_W'(MAX_OUTSTANDING);

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  step_q, step_d;
    logic [OFF_BITS-1:0]   req_off_q, req_off_d;
    logic [CNT_W-1:0]      issue_q, issue_d;
    logic [CNT_W-1:0]      rc_q, rc_d;
    logic [OUT_W-1:0]      outst_q, outst_d;
    logic [DATA_W-1:0]     dout_q, dout_d;
    logic                  ovalid_q, ovalid_d;

    logic                  st_we, st_inval, st_fill_done, st_valid, accept;
    logic [OFF_BITS-1:0]   st_widx;
    logic [DATA_W-1:0]     st_wdata, st_rd_data;
    logic [TAG_BITS-1:0]   st_tag, up_tag, lat_tag;

    assign up_tag  = up_address[ADDR_W-1:OFF_BITS];
    assign lat_tag = addr_q[ADDR_W-1:OFF_BITS];

    pfb_line_store #(
        .WORDS   (LINE_WORDS),
        .IDX_W   (OFF_BITS),
        .TAG_BITS(TAG_BITS)
    ) u_store (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .wr_en_i    (st_we),
        .wr_idx_i   (st_widx),
        .wr_data_i  (st_wdata),
        .inval_i    (st_inval),
        .fill_done_i(st_fill_done),
        .tag_i      (lat_tag),
        .rd_idx_i   (up_address[OFF_BITS-1:0]),
        .rd_data_o  (st_rd_data),
        .tag_o      (st_tag),
        .valid_o    (st_valid)
    );

    always_comb begin
        state_d           = state_q;
        addr_d            = addr_q;
        wdata_d           = wdata_q;
        step_d            = step_q;
        req_off_d         = req_off_q;
        issue_d           = issue_q;
        rc_d              = rc_q;
        outst_d           = outst_q;
        dout_d            = dout_q;
        ovalid_d          = 1'b0;
        up_busy           = 1'b1;
        ctl_address       = '0;
        ctl_rw            = 1'b0;
        ctl_data_in       = '0;
        ctl_in_valid      = 1'b0;
        ctl_prefetch_step = 1'b0;
        st_we             = 1'b0;
        st_widx           = '0;
        st_wdata          = '0;
        st_inval          = 1'b0;
        st_fill_done      = 1'b0;
        accept            = 1'b0;
        // Outputs are forced quiet while reset is held, before the reset edge lands.
        if (rst_n) begin
            unique case (state_q)
                IDLE: begin
                    up_busy = 1'b0;
                    if (up_in_valid) begin
                        addr_d  = up_address;
                        wdata_d = up_data_in;
                        step_d  = up_prefetch_step;
                        if (up_rw) begin
                            state_d = WR_PASS;
                        end else if (st_valid && (st_tag == up_tag)) begin
                            state_d  = HIT;
                            dout_d   = st_rd_data;
                            ovalid_d = 1'b1;
                        end else begin
                            state_d   = FILL;
                            req_off_d = up_address[OFF_BITS-1:0];
                            issue_d   = '0;
                            rc_d      = '0;
                            outst_d   = '0;
                            st_inval  = 1'b1;
                        end
                    end
                end
                HIT: state_d = IDLE;
                WR_PASS: begin
                    ctl_in_valid      = 1'b1;
                    ctl_rw            = 1'b1;
                    ctl_address       = addr_q;
                    ctl_data_in       = wdata_q;
                    ctl_prefetch_step = step_q;
                    if (!ctl_busy) begin
                        state_d = IDLE;
                        if (st_valid && (st_tag == lat_tag)) begin
                            st_we    = 1'b1;
                            st_widx  = addr_q[OFF_BITS-1:0];
                            st_wdata = wdata_q;
                        end
                    end
                end
                FILL: begin
                    ctl_in_valid = (issue_q < LINE_CNT) && (outst_q < MAX_OUT);
                    ctl_address  = {lat_tag, issue_q[OFF_BITS-1:0]};
                    accept       = ctl_in_valid && !ctl_busy;
                    if (accept) begin
                        issue_d = issue_q + 1'b1;
                    end
                    outst_d = outst_q + OUT_W'(accept) - OUT_W'(ctl_out_valid);
                    if (ctl_out_valid) begin
                        st_we    = 1'b1;
                        st_widx  = rc_q[OFF_BITS-1:0];
                        st_wdata = ctl_data_out;
                        rc_d     = rc_q + 1'b1;
                        if (rc_q[OFF_BITS-1:0] == req_off_q) begin
                            dout_d   = ctl_data_out;
                            ovalid_d = 1'b1;
                        end
                        if (rc_q == LAST_RC) begin
                            st_fill_done = 1'b1;
                            state_d      = IDLE;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            step_q    <= 1'b0;
            req_off_q <= '0;
            issue_q   <= '0;
            rc_q      <= '0;
            outst_q   <= '0;
            dout_q    <= '0;
            ovalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            step_q    <= step_d;
            req_off_q <= req_off_d;
            issue_q   <= issue_d;
            rc_q      <= rc_d;
            outst_q   <= outst_d;
            dout_q    <= dout_d;
            ovalid_q  <= ovalid_d;
        end
    end

    assign up_data_out  = dout_q;
    assign up_out_valid = ovalid_q;
endmodule

// File: tb/tb_sdram_prefetch_buffer.sv
// Self-checking bench: table vectors, multi-cycle corner sequences and random traffic against a transparent-memory model.
module tb_sdram_prefetch_buffer;
    localparam int unsigned LW = 8;
    localparam int unsigned AW = 24;
    localparam int unsigned MO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] up_address = '0;
    logic          up_rw = 1'b0;
    logic [31:0]   up_data_in = '0;
    logic [31:0]   up_data_out;
    logic          up_busy;
    logic          up_in_valid = 1'b0;
    logic          up_out_valid;
    logic          up_prefetch_step = 1'b0;
    logic [AW-1:0] ctl_address;
    logic          ctl_rw;
    logic [31:0]   ctl_data_in;
    logic [31:0]   ctl_data_out = '0;
    logic          ctl_busy = 1'b0;
    logic          ctl_in_valid;
    logic          ctl_out_valid = 1'b0;
    logic          ctl_prefetch_step;

    always #5 clk = ~clk;

    sdram_prefetch_buffer #(
        .LINE_WORDS(LW),
        .ADDR_W(AW),
        .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .up_address(up_address), .up_rw(up_rw), .up_data_in(up_data_in),
        .up_data_out(up_data_out), .up_busy(up_busy), .up_in_valid(up_in_valid),
        .up_out_valid(up_out_valid), .up_prefetch_step(up_prefetch_step),
        .ctl_address(ctl_address), .ctl_rw(ctl_rw), .ctl_data_in(ctl_data_in),
        .ctl_data_out(ctl_data_out), .ctl_busy(ctl_busy), .ctl_in_valid(ctl_in_valid),
        .ctl_out_valid(ctl_out_valid), .ctl_prefetch_step(ctl_prefetch_step)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Controller model: memory defaults to address+0x1000, fixed read latency, optional busy toggling.
    typedef struct { int due; logic [31:0] data; } ret_t;
    ret_t        pipe[$];
    logic [31:0] cmem[int unsigned];
    int unsigned rd_log[$];
    int          busy_mode = 0, lat = 2, cyc = 0;
    int          outst = 0, peak = 0, ret_cnt = 0, rd_step_bad = 0, wr_count = 0;
    int unsigned wr_addr_last = 0;
    logic [31:0] wr_data_last = '0;
    logic        wr_step_last = 1'b0;

    always @(negedge clk) begin : ctl_model
        ret_t r;
        int unsigned a;
        cyc++;
        ctl_out_valid = 1'b0;
        if (pipe.size() > 0 && pipe[0].due <= cyc) begin
            r = pipe.pop_front();
            ctl_out_valid = 1'b1;
            ctl_data_out  = r.data;
            outst--;
            ret_cnt++;
        end
        ctl_busy = (busy_mode != 0) && ((cyc % 2) == 1);
        if (rst_n && ctl_in_valid && !ctl_busy) begin
            a = int'(ctl_address);
            if (ctl_rw) begin
                cmem[a] = ctl_data_in;
                wr_count++;
                wr_addr_last = a;
                wr_data_last = ctl_data_in;
                wr_step_last = ctl_prefetch_step;
            end else begin
                rd_log.push_back(a);
                if (ctl_prefetch_step) rd_step_bad++;
                r.due  = cyc + lat;
                r.data = cmem.exists(a) ? cmem[a] : a + 32'h1000;
                pipe.push_back(r);
                outst++;
                if (outst > peak) peak = outst;
            end
        end
    end

    // Reference: the buffer is transparent, so reads return the latest written value or the default.
    logic [31:0] rmem[int unsigned];
    bit          line_v = 1'b0;
    int unsigned line_base = 0;

    function automatic logic [31:0] ref_rd(input int unsigned a);
        return rmem.exists(a) ? rmem[a] : a + 32'h1000;
    endfunction

    function automatic bit ref_hit(input int unsigned a);
        return line_v && (line_base == (a & ~(LW - 1)));
    endfunction

    task automatic do_req(input bit rw, input int unsigned a, input logic [31:0] d, input bit step,
                          input logic [31:0] exp_data, input int exp_reads, input bit exp_hit,
                          input string nm);
        int n, pulses, first_lat, w0;
        logic [31:0] got;
        int unsigned base;
        bit order_ok;
        outst = 0; peak = 0; rd_step_bad = 0;
        rd_log.delete();
        w0 = wr_count;
        @(negedge clk);
        up_in_valid = 1'b1; up_rw = rw; up_address = AW'(a); up_data_in = d; up_prefetch_step = step;
        n = 0;
        while (up_busy && n < 200) begin @(negedge clk); n++; end
        chk({nm, "_accept_timeout"}, 32'(up_busy), 32'd0);
        @(posedge clk); #1;
        up_in_valid = 1'b0;
        n = 0; pulses = 0; first_lat = 0; got = '0;
        while (n < 300) begin
            @(negedge clk); n++;
            if (up_out_valid) begin
                if (pulses == 0) begin first_lat = n; got = up_data_out; end
                pulses++;
            end
            if (!up_busy) break;
        end
        chk({nm, "_done_timeout"}, 32'(up_busy), 32'd0);
        chk({nm, "_pulses"}, 32'(pulses), rw ? 32'd0 : 32'd1);
        chk({nm, "_ctl_reads"}, 32'(rd_log.size()), 32'(exp_reads));
        if (!rw) chk({nm, "_data"}, got, exp_data);
        if (exp_hit) chk({nm, "_hit_latency"}, 32'(first_lat), 32'd1);
        if (exp_reads == int'(LW)) begin
            base = a & ~(LW - 1);
            order_ok = 1'b1;
            foreach (rd_log[i]) if (rd_log[i] != base + i) order_ok = 1'b0;
            chk({nm, "_fill_order"}, 32'(order_ok), 32'd1);
            chk({nm, "_outstanding_le_max"}, 32'(peak <= int'(MO)), 32'd1);
            chk({nm, "_fill_step"}, 32'(rd_step_bad), 32'd0);
        end
        if (rw) begin
            chk({nm, "_writes"}, 32'(wr_count - w0), 32'd1);
            chk({nm, "_wr_addr"}, wr_addr_last, a);
            chk({nm, "_wr_data"}, wr_data_last, d);
            chk({nm, "_wr_step"}, 32'(wr_step_last), 32'(step));
            rmem[a] = d;
        end else begin
            line_v = 1'b1;
            line_base = a & ~(LW - 1);
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_up_busy"}, 32'(up_busy), 32'd1);
        chk({nm, "_up_out_valid"}, 32'(up_out_valid), 32'd0);
        chk({nm, "_ctl_in_valid"}, 32'(ctl_in_valid), 32'd0);
        chk({nm, "_ctl_fields"}, {7'd0, ctl_rw, ctl_prefetch_step, ctl_address}, 32'd0);
        chk({nm, "_ctl_data_in"}, ctl_data_in, 32'd0);
    endtask

    typedef struct {
        bit          rw;
        int unsigned addr;
        logic [31:0] wdata;
        bit          step;
        logic [31:0] exp_data;
        int          exp_reads;
        bit          exp_hit;
    } vec_t;
    vec_t vecs[9];

    initial begin
        int n;
        bit rw, step;
        int unsigned a;
        logic [31:0] d;

        vecs[0] = '{1'b0, 32'h13,     32'h0,        1'b0, 32'h1013,     8, 1'b0};
        vecs[1] = '{1'b0, 32'h16,     32'h0,        1'b0, 32'h1016,     0, 1'b1};
        vecs[2] = '{1'b1, 32'h15,     32'hDEADBEEF, 1'b1, 32'h0,        0, 1'b0};
        vecs[3] = '{1'b0, 32'h15,     32'h0,        1'b0, 32'hDEADBEEF, 0, 1'b1};
        vecs[4] = '{1'b0, 32'h25,     32'h0,        1'b0, 32'h1025,     8, 1'b0};
        vecs[5] = '{1'b0, 32'h15,     32'h0,        1'b0, 32'hDEADBEEF, 8, 1'b0};
        vecs[6] = '{1'b1, 32'h40,     32'h12345678, 1'b0, 32'h0,        0, 1'b0};
        vecs[7] = '{1'b0, 32'h40,     32'h0,        1'b0, 32'h12345678, 8, 1'b0};
        vecs[8] = '{1'b0, 32'hFFFFFF, 32'h0,        1'b0, 32'h01000FFF, 8, 1'b0};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        chk("reset_up_data_out", up_data_out, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        foreach (vecs[i])
            do_req(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].step,
                   vecs[i].exp_data, vecs[i].exp_reads, vecs[i].exp_hit, $sformatf("vec%0d", i));

        // Requested word at offset 7 arrives last, under busy toggling and 3-cycle latency.
        busy_mode = 1; lat = 3;
        do_req(1'b0, 32'h37, 32'h0, 1'b0, 32'h1037, 8, 1'b0, "busy_off7");

        // Reset after three returns of a fill; leftover returns arrive while idle.
        ret_cnt = 0;
        @(negedge clk);
        up_in_valid = 1'b1; up_rw = 1'b0; up_address = AW'(32'h23);
        @(posedge clk); #1;
        up_in_valid = 1'b0;
        n = 0;
        while (ret_cnt < 3 && n < 100) begin @(negedge clk); n++; end
        chk("midfill_returns_timeout", 32'(ret_cnt >= 3), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("midfill_reset");
        @(negedge clk);
        chk("midfill_reset_busy2", 32'(up_busy), 32'd1);
        rst_n = 1'b1;
        line_v = 1'b0;
        repeat (12) @(negedge clk);
        chk("stale_no_pulse", 32'(up_out_valid), 32'd0);
        do_req(1'b0, 32'h10, 32'h0, 1'b0, 32'h1010, 8, 1'b0, "refill");

        for (int k = 0; k < 60; k++) begin
            rw   = ($urandom_range(0, 3) == 0);
            a    = $urandom_range(0, 47);
            d    = $urandom;
            step = $urandom_range(0, 1) == 1;
            busy_mode = $urandom_range(0, 1);
            lat  = $urandom_range(1, 4);
            do_req(rw, a, d, step, ref_rd(a),
                   (rw || ref_hit(a)) ? 0 : int'(LW), !rw && ref_hit(a), $sformatf("rnd%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
